// File: rtl/serial_and_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_and_pkg
// Description : Shared constants and state type for the serial AND receiver.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_and_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    HOLD  = ST_HOLD
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_and_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_and_deser_if
// Description : Serial bit input plus valid/ready result output bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_and_deser_if
  import serial_and_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             bit_valid;
  logic             start;
  logic             a;
  logic             b;
  logic [WIDTH-1:0] y;
  logic             y_valid;
  logic             y_ready;
  logic             all_ones;
  logic             busy;

  // Source of serial bits and consumer of result words.
  modport master (
    output bit_valid, start, a, b, y_ready,
    input  y, y_valid, all_ones, busy
  );

  // The receiver itself.
  modport slave (
    input  bit_valid, start, a, b, y_ready,
    output y, y_valid, all_ones, busy
  );
endinterface
`default_nettype wire

// File: rtl/serial_and_deser_frame_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_counter
// Description : Bit index counter for one frame; flags the last bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_counter
  import serial_and_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW   = $clog2(WIDTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          load1,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          last
);

  // Index register: clear wins over load-1, which wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= CW'(1);
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign last = (count == CW'(WIDTH - 1));

endmodule
`default_nettype wire

// File: rtl/serial_and_deser.sv
`default_nettype none
// ============================================================================
// Module      : serial_and_deser
// Description : Bit-serial AND receiver assembling a WIDTH-bit result word,
//               presented on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_and_deser
  import serial_and_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  serial_and_deser_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  // A one-bit frame is complete as soon as bit 0 lands.
  localparam state_t AFTER_BIT0 = (WIDTH == 1) ? HOLD : SHIFT;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] y_reg;
  logic [WIDTH-1:0] y_next;
  logic             y_valid_reg;
  logic             busy_reg;
  logic             all_ones_reg;

  logic             cnt_clear;
  logic             cnt_load1;
  logic             cnt_inc;
  logic [CW-1:0]    count;
  logic             last;

  logic             bit_and;
  logic             capture0;
  logic             do_start;

  assign bit_and  = bus.a & bus.b;
  assign capture0 = bus.bit_valid & bus.start;

  frame_counter #(
    .WIDTH (WIDTH)
  ) u_frame_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .load1 (cnt_load1),
    .inc   (cnt_inc),
    .count (count),
    .last  (last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, next-word and counter control.
  always_comb begin
    state_next = state;
    y_next     = y_reg;
    cnt_clear  = 1'b0;
    cnt_load1  = 1'b0;
    cnt_inc    = 1'b0;
    do_start   = 1'b0;

    case (state)
      IDLE: begin
        if (capture0) do_start = 1'b1;
      end
      SHIFT: begin
        if (bus.bit_valid) begin
          if (bus.start) begin
            // Restart: the partial word is abandoned.
            do_start = 1'b1;
          end else begin
            for (int i = 0; i < WIDTH; i++) begin
              if (i == int'(count)) y_next[i] = bit_and;
            end
            if (last) begin
              state_next = HOLD;
              cnt_clear  = 1'b1;
            end else begin
              cnt_inc = 1'b1;
            end
          end
        end
      end
      HOLD: begin
        // Bits arriving without a handshake are dropped.
        if (bus.y_ready) begin
          if (capture0) state_next = IDLE;
          if (capture0) do_start = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_clear  = 1'b1;
      end
    endcase

    // Bit 0 of a new frame clears every other bit of the word.
    if (do_start) begin
      y_next     = '0;
      y_next[0]  = bit_and;
      state_next = AFTER_BIT0;
      if (WIDTH == 1) cnt_clear = 1'b1;
      else            cnt_load1 = 1'b1;
    end
  end

  // Registered outputs, derived from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg        <= '0;
      y_valid_reg  <= 1'b0;
      busy_reg     <= 1'b0;
      all_ones_reg <= 1'b0;
    end else begin
      y_reg        <= y_next;
      y_valid_reg  <= (state_next == HOLD);
      busy_reg     <= (state_next == SHIFT);
      all_ones_reg <= (state_next == HOLD) & (&y_next);
    end
  end

  assign bus.y        = y_reg;
  assign bus.y_valid  = y_valid_reg;
  assign bus.busy     = busy_reg;
  assign bus.all_ones = all_ones_reg;

endmodule
`default_nettype wire

// File: tb/tb_serial_and_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_and_deser
// Description : Self-checking bench for serial_and_deser (WIDTH=8 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_and_deser;
  import serial_and_pkg::*;

  logic clk;
  logic rst_n;
  int   passed = 0;
  int   failed = 0;
  int   total  = 0;

  serial_and_deser_if #(.WIDTH(8)) bus8 ();
  serial_and_deser_if #(.WIDTH(1)) bus1 ();

  serial_and_deser #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  serial_and_deser #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one 8-bit frame LSB first with 'gap' idle cycles between bits and
  // check the result against the word-level rule y = a & b.
  task automatic send8(input logic [7:0] aw, input logic [7:0] bw, input int gap, input string tag);
    logic [7:0] exp;
    exp = aw & bw;
    for (int i = 0; i < 8; i++) begin
      bus8.bit_valid = 1'b1;
      bus8.start     = (i == 0);
      bus8.a         = aw[i];
      bus8.b         = bw[i];
      tick();
      bus8.bit_valid = 1'b0;
      bus8.start     = 1'b0;
      if (i < 7) begin
        check($sformatf("%s busy b%0d", tag, i), 32'(bus8.busy), 32'd1);
        check($sformatf("%s nvalid b%0d", tag, i), 32'(bus8.y_valid), 32'd0);
        for (int g = 0; g < gap; g++) begin
          tick();
          check($sformatf("%s busy gap b%0d", tag, i), 32'(bus8.busy), 32'd1);
        end
      end
    end
    check($sformatf("%s y", tag), 32'(bus8.y), 32'(exp));
    check($sformatf("%s y_valid", tag), 32'(bus8.y_valid), 32'd1);
    check($sformatf("%s all_ones", tag), 32'(bus8.all_ones), 32'(exp == 8'hFF));
    check($sformatf("%s busy end", tag), 32'(bus8.busy), 32'd0);
    if (bus8.y_ready) begin
      tick();
      check($sformatf("%s valid 1cyc", tag), 32'(bus8.y_valid), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;

    rst_n          = 1'b0;
    bus8.bit_valid = 1'b0; bus8.start = 1'b0; bus8.a = 1'b0; bus8.b = 1'b0; bus8.y_ready = 1'b0;
    bus1.bit_valid = 1'b0; bus1.start = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.y_ready = 1'b0;
    tick();
    tick();

    // Reset values.
    check("rst y", 32'(bus8.y), 32'd0);
    check("rst y_valid", 32'(bus8.y_valid), 32'd0);
    check("rst all_ones", 32'(bus8.all_ones), 32'd0);
    check("rst busy", 32'(bus8.busy), 32'd0);
    check("rst w1 y_valid", 32'(bus1.y_valid), 32'd0);
    rst_n = 1'b1;
    tick();

    // Non-start bits in IDLE are ignored.
    bus8.bit_valid = 1'b1; bus8.a = 1'b1; bus8.b = 1'b1;
    tick();
    bus8.bit_valid = 1'b0;
    check("idle ignore busy", 32'(bus8.busy), 32'd0);

    // Basic frame.
    bus8.y_ready = 1'b1;
    send8(8'hF0, 8'h3C, 0, "basic");

    // All ones with gaps.
    send8(8'hFF, 8'hFF, 3, "ones");

    // Backpressure, then back-to-back start coinciding with the handshake.
    bus8.y_ready = 1'b0;
    send8(8'hAA, 8'hFF, 0, "bp1");
    for (int k = 0; k < 5; k++) begin
      bus8.bit_valid = 1'b1;
      bus8.start     = 1'b0;
      bus8.a         = 1'($urandom);
      bus8.b         = 1'($urandom);
      tick();
      check($sformatf("bp hold y %0d", k), 32'(bus8.y), 32'hAA);
      check($sformatf("bp hold valid %0d", k), 32'(bus8.y_valid), 32'd1);
    end
    bus8.bit_valid = 1'b0;
    bus8.y_ready   = 1'b1;
    send8(8'h0F, 8'h0F, 0, "b2b");

    // Restart after 4 bits of a partial all-ones frame.
    for (int i = 0; i < 4; i++) begin
      bus8.bit_valid = 1'b1;
      bus8.start     = (i == 0);
      bus8.a         = 1'b1;
      bus8.b         = 1'b1;
      tick();
    end
    send8(8'h81, 8'h81, 0, "restart");

    // Asynchronous reset between clock edges during SHIFT.
    for (int i = 0; i < 3; i++) begin
      bus8.bit_valid = 1'b1;
      bus8.start     = (i == 0);
      bus8.a         = 1'b1;
      bus8.b         = 1'b1;
      tick();
    end
    bus8.bit_valid = 1'b0;
    bus8.start     = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(bus8.busy), 32'd0);
    check("arst y", 32'(bus8.y), 32'd0);
    check("arst y_valid", 32'(bus8.y_valid), 32'd0);
    check("arst all_ones", 32'(bus8.all_ones), 32'd0);
    #3;
    rst_n = 1'b1;
    tick();
    send8(8'h55, 8'h55, 0, "post_rst");

    // WIDTH=1 instance.
    bus1.y_ready   = 1'b1;
    bus1.bit_valid = 1'b1; bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
    tick();
    bus1.bit_valid = 1'b0; bus1.start = 1'b0;
    check("w1 y", 32'(bus1.y), 32'd1);
    check("w1 y_valid", 32'(bus1.y_valid), 32'd1);
    check("w1 all_ones", 32'(bus1.all_ones), 32'd1);
    check("w1 busy", 32'(bus1.busy), 32'd0);
    tick();
    check("w1 valid drop", 32'(bus1.y_valid), 32'd0);
    check("w1 busy idle", 32'(bus1.busy), 32'd0);
    bus1.bit_valid = 1'b1; bus1.start = 1'b1; bus1.a = 1'b1; bus1.b = 1'b0;
    tick();
    bus1.bit_valid = 1'b0; bus1.start = 1'b0;
    check("w1b y", 32'(bus1.y), 32'd0);
    check("w1b all_ones", 32'(bus1.all_ones), 32'd0);
    check("w1b busy", 32'(bus1.busy), 32'd0);

    // Randomized frames with random gaps.
    for (int f = 0; f < 20; f++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      send8(ra, rb, int'($urandom_range(0, 2)), $sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
